// File: rtl/radio_module.sv
// Radio front-end: generates the radio/MCU clocks, double-registers the
// 2-bit I/Q samples of both radios and serialises each 8-bit frame MSB
// first onto DATA_OUT, with a SYNC strobe on the first bit of every frame
// and a frame-counter heartbeat on MISC.
module radio_module #(
  parameter int CLK3_DIV = 2,
  parameter int HB_LOG2  = 4
) (
  input  logic       SYS_CLK,
  input  logic       RST_N,
  input  logic [1:0] R0_I,
  input  logic [1:0] R0_Q,
  input  logic [1:0] R1_I,
  input  logic [1:0] R1_Q,
  output logic       DATA_OUT,
  output logic       SYNC,
  output logic       MISC,
  output logic       CLK_OUT1,
  output logic       CLK_OUT2,
  output logic       CLK_OUT3
);

  // Half period of CLK_OUT3 in SYS_CLK cycles, and its counter width.
  localparam int HALF3 = CLK3_DIV / 2;
  localparam int C3W   = (HALF3 > 1) ? $clog2(HALF3) : 1;
  localparam logic [C3W-1:0] C3_LAST = C3W'(HALF3 - 1);

  logic [2:0]         bit_cnt;
  logic               frame_end;
  logic [7:0]         in_q1;
  logic [7:0]         in_q2;
  logic [7:0]         shreg;
  logic [HB_LOG2-1:0] frame_cnt;
  logic [C3W-1:0]     div3_cnt;
  logic               clk3;
  logic               radio_clk;

  // RST_N release is expected to be aligned to SYS_CLK by the board
  // reset logic, so it drives the async clears directly.

  // Last bit slot of the frame: reload point for the shifter.
  assign frame_end = (bit_cnt == 3'd7);

  // Free-running bit slot counter, wraps 7 -> 0.
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) bit_cnt <= '0;
    else        bit_cnt <= bit_cnt + 3'd1;
  end

  // Two-flop capture of the radio samples, packed in frame bit order.
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      in_q1 <= '0;
      in_q2 <= '0;
    end else begin
      in_q1 <= {R0_I, R0_Q, R1_I, R1_Q};
      in_q2 <= in_q1;
    end
  end

  // Frame shifter: load at the frame boundary, otherwise shift out MSB first.
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N)         shreg <= '0;
    else if (frame_end) shreg <= in_q2;
    else                shreg <= {shreg[6:0], 1'b0};
  end

  // SYNC marks the cycle in which DATA_OUT carries the frame MSB.
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) SYNC <= 1'b0;
    else        SYNC <= frame_end;
  end

  // Radio clock tracks the post-edge bit_cnt[2]: it rises on the 3->4 edge,
  // so the radios update well before the capture at bit_cnt==7.
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) radio_clk <= 1'b0;
    else        radio_clk <= bit_cnt[1] & bit_cnt[0] ? ~bit_cnt[2] : bit_cnt[2];
  end

  // Frame counter for the heartbeat; wraps freely.
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N)         frame_cnt <= '0;
    else if (frame_end) frame_cnt <= frame_cnt + 1'b1;
  end

  // Heartbeat register: follows the frame counter MSB after each increment.
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N)         MISC <= 1'b0;
    else if (frame_end) MISC <= frame_cnt_next_msb(frame_cnt);
  end

  // MCU clock divider: toggle each time the half-period counter wraps.
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      div3_cnt <= '0;
      clk3     <= 1'b0;
    end else if (div3_cnt == C3_LAST) begin
      div3_cnt <= '0;
      clk3     <= ~clk3;
    end else begin
      div3_cnt <= div3_cnt + 1'b1;
    end
  end

  // MSB of the frame counter after it increments.
  function automatic logic frame_cnt_next_msb(input logic [HB_LOG2-1:0] cnt);
    logic [HB_LOG2-1:0] nxt;
    nxt = cnt + 1'b1;
    return nxt[HB_LOG2-1];
  endfunction

  assign DATA_OUT = shreg[7];
  assign CLK_OUT1 = radio_clk;
  assign CLK_OUT2 = radio_clk;
  assign CLK_OUT3 = clk3;

endmodule

// File: tb/tb_radio_module.sv
// Self-checking bench for radio_module. The reference model counts edges
// since reset release and derives every output from that count and a
// history of the sampled inputs.
module tb_radio_module;

  logic       SYS_CLK = 1'b0;
  logic       RST_N   = 1'b1;
  logic [1:0] R0_I = '0, R0_Q = '0, R1_I = '0, R1_Q = '0;
  logic       DATA_OUT, SYNC, MISC, CLK_OUT1, CLK_OUT2, CLK_OUT3;
  logic       d6_data, d6_sync, d6_misc, d6_clk1, d6_clk2, d6_clk3;

  int         compared   = 0;
  int         mismatched = 0;
  int         n          = 0;      // edges since reset release
  logic [7:0] hist [0:511];        // inputs sampled at edge k
  logic [7:0] acc;                 // observed serial bits
  logic [7:0] last_byte;           // last fully observed frame

  radio_module #(.CLK3_DIV(2), .HB_LOG2(4)) dut (
    .SYS_CLK(SYS_CLK), .RST_N(RST_N),
    .R0_I(R0_I), .R0_Q(R0_Q), .R1_I(R1_I), .R1_Q(R1_Q),
    .DATA_OUT(DATA_OUT), .SYNC(SYNC), .MISC(MISC),
    .CLK_OUT1(CLK_OUT1), .CLK_OUT2(CLK_OUT2), .CLK_OUT3(CLK_OUT3)
  );

  radio_module #(.CLK3_DIV(6), .HB_LOG2(4)) dut6 (
    .SYS_CLK(SYS_CLK), .RST_N(RST_N),
    .R0_I(R0_I), .R0_Q(R0_Q), .R1_I(R1_I), .R1_Q(R1_Q),
    .DATA_OUT(d6_data), .SYNC(d6_sync), .MISC(d6_misc),
    .CLK_OUT1(d6_clk1), .CLK_OUT2(d6_clk2), .CLK_OUT3(d6_clk3)
  );

  always #10 SYS_CLK = ~SYS_CLK;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, got, exp);
    end
  endtask

  task automatic set_in(input logic [7:0] v);
    {R0_I, R0_Q, R1_I, R1_Q} = v;
  endtask

  // Advance one edge, record the sampled inputs, then check against the model.
  task automatic step();
    logic [7:0] frame;
    logic       e_data;
    @(posedge SYS_CLK);
    n++;
    hist[n] = {R0_I, R0_Q, R1_I, R1_Q};
    #1;
    if (n >= 8) begin
      frame  = hist[(n / 8) * 8 - 2];
      e_data = frame[7 - (n % 8)];
    end else begin
      e_data = 1'b0;
    end
    chk("data", {7'd0, DATA_OUT}, {7'd0, e_data});
    chk("sync", {7'd0, SYNC}, {7'd0, (n >= 8 && n % 8 == 0)});
    chk("clk1", {7'd0, CLK_OUT1}, {7'd0, (n % 8 >= 4)});
    chk("clk2", {7'd0, CLK_OUT2}, {7'd0, (n % 8 >= 4)});
    chk("misc", {7'd0, MISC}, {7'd0, ((n / 8) % 16 >= 8)});
    chk("clk3_div2", {7'd0, CLK_OUT3}, {7'd0, (n % 2 == 1)});
    chk("clk3_div6", {7'd0, d6_clk3}, {7'd0, ((n / 3) % 2 == 1)});
    if (n >= 8) begin
      acc = {acc[6:0], DATA_OUT};
      if (n % 8 == 7) last_byte = acc;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {2'b0, DATA_OUT, SYNC, MISC, CLK_OUT1, CLK_OUT2, CLK_OUT3}, 8'h00);
    chk(tag, {2'b0, d6_data, d6_sync, d6_misc, d6_clk1, d6_clk2, d6_clk3}, 8'h00);
  endtask

  initial begin
    acc = '0; last_byte = '0;
    set_in(8'h1B);                       // R0_I=00 R0_Q=01 R1_I=10 R1_Q=11
    #2 RST_N = 1'b0;
    // Reset held with clock running
    repeat (3) begin
      @(posedge SYS_CLK); #1;
      chk_all_zero("reset_hold");
    end
    @(negedge SYS_CLK); RST_N = 1'b1; n = 0;

    // Constant pattern, first frame and repeat
    while (n < 15) step();
    chk("frame0", last_byte, 8'h1B);
    while (n < 26) step();               // bit_cnt == 2 inside the second full frame
    set_in(8'hFF);
    while (n < 31) step();
    chk("frame_midchange", last_byte, 8'h1B);
    while (n < 39) step();
    chk("frame_ff", last_byte, 8'hFF);

    // Random inputs changing at random times; covers heartbeat rise and fall
    while (n < 140) begin
      step();
      if ($urandom_range(3) == 0) set_in(8'($urandom));
    end

    // Asynchronous reset in the middle of a frame
    while (n % 8 != 5) step();
    @(negedge SYS_CLK); RST_N = 1'b0; #1;
    chk_all_zero("reset_async");
    @(posedge SYS_CLK); #1;
    chk_all_zero("reset_async_hold");
    @(negedge SYS_CLK); RST_N = 1'b1; n = 0;

    // Framing restarts from zero after the mid-frame reset
    set_in(8'hA5);
    while (n < 15) step();
    chk("frame_after_reset", last_byte, 8'hA5);
    while (n < 40) begin
      step();
      if ($urandom_range(2) == 0) set_in(8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/radio_module.md
Name: radio_module

Overview:
- Front-end FPGA block of the radio module. Clocks two dual-channel 2-bit radios and captures their I/Q samples.
- Serialises each 8-bit sample frame onto one output line, with a frame SYNC strobe.
- Provides a divided clock to the microcontroller and a heartbeat on MISC.
- Sits between the radio ADC outputs and the downstream serial link.

Parameters:
- CLK3_DIV, 2: SYS_CLK divide ratio for CLK_OUT3. Even, >=2.
- HB_LOG2, 4: width of the frame counter. MISC = frame_cnt[HB_LOG2-1]. Range >=1.

Ports:
- SYS_CLK in 1: system clock. All logic on its rising edge.
- RST_N in 1: reset, asynchronous assert, active-low. Release is synchronous to SYS_CLK.
- R0_I in 2: radio 0 in-phase sample.
- R0_Q in 2: radio 0 quadrature sample.
- R1_I in 2: radio 1 in-phase sample.
- R1_Q in 2: radio 1 quadrature sample.
- DATA_OUT out 1: serial frame data, MSB first, one bit per SYS_CLK.
- SYNC out 1: high for exactly the cycle DATA_OUT carries the first bit of a frame.
- MISC out 1: heartbeat, frame-counter bit.
- CLK_OUT1 out 1: clock to radio 0, SYS_CLK/8.
- CLK_OUT2 out 1: clock to radio 1, identical to CLK_OUT1.
- CLK_OUT3 out 1: clock to microcontroller, SYS_CLK/CLK3_DIV, 50% duty.

Behaviour:
- Interface: one clock (SYS_CLK); reset RST_N is asynchronous and active-low.
- While RST_N=0, every register is 0. All outputs are 0: DATA_OUT, SYNC, MISC, CLK_OUT1/2/3.
- All outputs are driven directly from registers, with no combinational paths from inputs.
- bit_cnt (3 bits): increments every cycle and wraps 7->0. Reset value 0.
- Input pipeline: in_q1 <= {R0_I,R0_Q,R1_I,R1_Q} every cycle; in_q2 <= in_q1. This gives two-flop capture.
- Shift register shreg (8 bits):
  - On an edge where bit_cnt==7, load shreg with in_q2.
  - Otherwise shift left by one, filling with 0.
- DATA_OUT = shreg[7].
- Frame bit order: R0_I[1], R0_I[0], R0_Q[1], R0_Q[0], R1_I[1], R1_I[0], R1_Q[1], R1_Q[0].
- SYNC register: SYNC <= (bit_cnt==7). SYNC is high for 1 cycle every 8, aligned with the frame's first bit.
- CLK_OUT1 = CLK_OUT2 = bit_cnt[2], registered.
  - Low for bit_cnt 0..3, high for 4..7. Rises on the edge where bit_cnt goes 3->4.
  - Radios update their outputs on this rising edge. Capture at bit_cnt==7 sees data at least 2 cycles old, so it is stable.
- Latency: an input held stable across edges k and k+1 is in in_q2 after edge k+1. It is loaded at the next bit_cnt==7 edge and appears on DATA_OUT over the following 8 cycles.
- First frame after reset:
  - Loads on the 8th rising edge after RST_N release.
  - Before that, DATA_OUT=0 and SYNC=0.
- frame_cnt (HB_LOG2 bits): increments on each bit_cnt==7 edge and wraps freely. MISC = frame_cnt[HB_LOG2-1].
- CLK_OUT3: divider counter counts 0..CLK3_DIV/2-1. The output toggles when the counter wraps.
  - First toggle (0->1) is CLK3_DIV/2 edges after reset release.
  - With CLK3_DIV=2, CLK_OUT3 toggles every edge.
- Reset mid-frame: all state clears immediately and asynchronously. The frame in flight is discarded. Framing restarts from bit_cnt=0.
- Inputs changing mid-frame do not affect the frame being shifted. They only affect the next load.

Test Plan:
- Reset check: hold RST_N=0 with SYS_CLK running. All outputs must read 0. Assert RST_N low mid-frame and all outputs must drop to 0 without waiting for a clock edge.
- Constant pattern R0_I=00, R0_Q=01, R1_I=10, R1_Q=11 (20 ns clock):
  - After the 8th edge post-release, SYNC=1 for one cycle.
  - DATA_OUT then shows 0,0,0,1,1,0,1,1 (0x1B), repeating every 8 cycles with SYNC each frame.
- Radio clocks: CLK_OUT1 == CLK_OUT2 at all times. Period is 8 SYS_CLK with 4 high, 4 low. First rise on the 4th edge after release. SYNC pulses while CLK_OUT1 is low.
- Input change mid-frame: switch all inputs to 11 at bit_cnt==2. The current frame is unchanged. The next frame is 0xFF.
- CLK_OUT3 with CLK3_DIV=2: toggles each edge (period 2 cycles). With CLK3_DIV=6: period 6 cycles, 3 high and 3 low.
- Heartbeat with HB_LOG2=4: MISC rises after 8 frames (64 cycles) and falls after 16 frames (128 cycles).
